// File: rtl/psum_accum_buffer_if.sv
// Output stream of the partial-sum buffer: requantized int8 lanes toward the output writer.
// The buffer drives the master side and the consumer drives the slave side.
interface psum_accum_buffer_if #(
    parameter int ARRAY_DIM = 16,
    parameter int ADDR_W    = 10
);
    logic                     out_valid;
    logic                     out_ready;
    logic [ARRAY_DIM*8-1:0]   out_data;
    logic [ADDR_W-1:0]        out_addr;
    logic                     out_last;

    modport master (output out_valid, output out_data, output out_addr, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_addr, input out_last, output out_ready);
endinterface

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulate buffer with round/shift/saturate drain to an int8 stream.
// Optional macro PSUM_RELU_EN clamps negative output lanes to zero.
module psum_accum_buffer #(
    parameter int ARRAY_DIM = 16,
    parameter int ACC_W     = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_enable,
    input  logic                       acc_clear,
    input  logic [ADDR_W-1:0]          acc_addr,
    input  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_out,
    input  logic                       drain_start,
    input  logic [ADDR_W:0]            drain_count,
    input  logic [4:0]                 shift,
    psum_accum_buffer_if.master        out_if,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       acc_overflow,
    output logic                       err_collision
);
    localparam int DATA_W = ARRAY_DIM * ACC_W;
    localparam int OUT_W  = ARRAY_DIM * 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PIPE = 3'd1,
        S_RD        = 3'd2,
        S_LOAD      = 3'd3,
        S_OUT       = 3'd4
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_addr;

    logic              s0_valid_d, s0_valid_q, s0_clear_q;
    logic [ADDR_W-1:0] s0_addr_q;
    logic [DATA_W-1:0] s0_data_q;
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    logic              ovf_event, fwd;
    logic [ACC_W-1:0]  old_l, add_l, sum_l;

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] idx_d, idx_q;
    logic [ADDR_W:0]   count_d, count_q;
    logic [4:0]        shift_d, shift_q;
    logic              wait_d, wait_q;
    logic              out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic [OUT_W-1:0]  out_data_d, out_data_q, requant_data;
    logic [ADDR_W-1:0] out_addr_d, out_addr_q;
    logic              drain_done_d, drain_done_q, busy_d, busy_q;
    logic              ovf_d, ovf_q, coll_d, coll_q, flag_clr;

    // Round half up, arithmetic shift, saturate to int8 (one guard bit above ACC_W).
    function automatic logic [7:0] requant(input logic [ACC_W-1:0] v, input logic [4:0] sh);
        logic signed [ACC_W:0] x;
        logic signed [ACC_W:0] rnd;
        logic [7:0]            r;
        x   = $signed({v[ACC_W-1], v});
        rnd = (sh != 5'd0) ? $signed({{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1)) : $signed({(ACC_W+1){1'b0}});
        x   = (x + rnd) >>> sh;
        if (x[ACC_W:7] == {(ACC_W-6){x[ACC_W]}}) begin
            r = x[7:0];
        end else if (x[ACC_W]) begin
            r = 8'h80;
        end else begin
            r = 8'h7F;
        end
`ifdef PSUM_RELU_EN
        r = r[7] ? 8'h00 : r;
`endif
        return r;
    endfunction

    // Stage-1 write data with forwarding of the entry written on the previous cycle
    always_comb begin
        s1_data_d = {DATA_W{1'b0}};
        ovf_event = 1'b0;
        old_l     = {ACC_W{1'b0}};
        add_l     = {ACC_W{1'b0}};
        sum_l     = {ACC_W{1'b0}};
        fwd       = s1_valid_q && (s1_addr_q == s0_addr_q);
        for (int i = 0; i < ARRAY_DIM; i++) begin
            old_l = fwd ? s1_data_q[i*ACC_W +: ACC_W] : rd_data_q[i*ACC_W +: ACC_W];
            add_l = s0_data_q[i*ACC_W +: ACC_W];
            sum_l = old_l + add_l;
            s1_data_d[i*ACC_W +: ACC_W] = s0_clear_q ? add_l : sum_l;
            if (s0_valid_q && !s0_clear_q && (old_l[ACC_W-1] == add_l[ACC_W-1])
                && (sum_l[ACC_W-1] != add_l[ACC_W-1])) begin
                ovf_event = 1'b1;
            end else begin
                ovf_event = ovf_event;
            end
        end
    end

    // Buffer RAM: write from stage 1, single registered read shared by accumulate and drain
    always_ff @(posedge clk) begin
        if (s0_valid_q) begin
            mem[s0_addr_q] <= s1_data_d;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Accumulate pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_clear_q <= 1'b0;
            s0_addr_q  <= {ADDR_W{1'b0}};
            s0_data_q  <= {DATA_W{1'b0}};
            s1_valid_q <= 1'b0;
            s1_addr_q  <= {ADDR_W{1'b0}};
            s1_data_q  <= {DATA_W{1'b0}};
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_clear_q <= acc_clear;
            s0_addr_q  <= acc_addr;
            s0_data_q  <= pe_acc_out;
            s1_valid_q <= s0_valid_q;
            s1_addr_q  <= s0_addr_q;
            s1_data_q  <= s1_data_d;
        end
    end

    // Per-lane requantization of the drained entry
    always_comb begin
        requant_data = {OUT_W{1'b0}};
        for (int i = 0; i < ARRAY_DIM; i++) begin
            requant_data[i*8 +: 8] = requant(rd_data_q[i*ACC_W +: ACC_W], shift_q);
        end
    end

    // Drain FSM next-state, output registers and sticky flags
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        shift_d      = shift_q;
        wait_d       = wait_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        drain_done_d = 1'b0;
        flag_clr     = 1'b0;
        rd_addr      = (state_q == S_IDLE) ? acc_addr : idx_q;
        s0_valid_d   = acc_enable && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    count_d  = drain_count;
                    shift_d  = shift;
                    flag_clr = 1'b1;
                    wait_d   = 1'b0;
                    if (drain_count == {(ADDR_W+1){1'b0}}) begin
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_PIPE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_PIPE: begin
                if (wait_q) begin
                    state_d = S_RD;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_RD: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                out_data_d  = requant_data;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                out_last_d  = ({1'b0, idx_q} == (count_q - {{ADDR_W{1'b0}}, 1'b1}));
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        drain_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        ovf_d  = (flag_clr ? 1'b0 : ovf_q) | ovf_event;
        coll_d = (flag_clr ? 1'b0 : coll_q) | (acc_enable && (state_q != S_IDLE));
    end

    // Drain FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= {ADDR_W{1'b0}};
            count_q      <= {(ADDR_W+1){1'b0}};
            shift_q      <= 5'd0;
            wait_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= {OUT_W{1'b0}};
            out_addr_q   <= {ADDR_W{1'b0}};
            drain_done_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            coll_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            wait_q       <= wait_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            drain_done_q <= drain_done_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            coll_q       <= coll_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign drain_done       = drain_done_q;
    assign acc_overflow     = ovf_q;
    assign err_collision    = coll_q;
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer: accumulate, hazard forwarding, requant, backpressure,
// flags, zero-count drain and asynchronous reset mid-drain.
module tb_psum_accum_buffer;
    localparam int AD = 16;
    localparam int AW = 10;
    localparam int DW = AD * 32;
    localparam int OW = AD * 8;

    logic          clk;
    logic          rst_n;
    logic          acc_enable;
    logic          acc_clear;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] pe_acc_out;
    logic          drain_start;
    logic [AW:0]   drain_count;
    logic [4:0]    shift;
    logic          busy;
    logic          drain_done;
    logic          acc_overflow;
    logic          err_collision;

    psum_accum_buffer_if #(.ARRAY_DIM(AD), .ADDR_W(AW)) ob ();

    psum_accum_buffer #(.ARRAY_DIM(AD), .ACC_W(32), .DEPTH(1024), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .acc_enable(acc_enable), .acc_clear(acc_clear),
        .acc_addr(acc_addr), .pe_acc_out(pe_acc_out), .drain_start(drain_start),
        .drain_count(drain_count), .shift(shift), .out_if(ob.master), .busy(busy),
        .drain_done(drain_done), .acc_overflow(acc_overflow), .err_collision(err_collision)
    );

    int checks = 0;
    int errors = 0;
    int first_valid;
    int done_cyc;
    logic [OW-1:0] cap_data [$];
    logic [AW-1:0] cap_addr [$];
    logic          cap_last [$];

    int req_in [AD] = '{1000, -1000, 383, -129, 6, 7, 100000, -100000,
                        127, -128, 128, 32'h7FFFFFFF, 32'h80000000, 0, 1, -1};
    int req_s3 [AD] = '{125, -125, 48, -16, 1, 1, 127, -128, 16, -16, 16, 127, -128, 0, 0, 0};
    int req_s0 [AD] = '{127, -128, 127, -128, 6, 7, 127, -128, 127, -128, 127, 127, -128, 0, 1, -1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] all_lanes(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < AD; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] pack32(input int v [AD]);
        logic [DW-1:0] r;
        for (int i = 0; i < AD; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_lanes(input int v [AD]);
        logic [OW-1:0] r;
        int t;
        for (int i = 0; i < AD; i++) begin
            t = v[i];
`ifdef PSUM_RELU_EN
            if (t < 0) t = 0;
`endif
            r[i*8 +: 8] = t[7:0];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_all(input int v);
        int a [AD];
        for (int i = 0; i < AD; i++) a[i] = v;
        return exp_lanes(a);
    endfunction

    task automatic strobe(input logic clr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_enable = 1'b1;
        acc_clear  = clr;
        acc_addr   = a;
        pe_acc_out = d;
        tick();
        acc_enable = 1'b0;
        acc_clear  = 1'b0;
    endtask

    // Pulse drain_start, then capture every presented entry until drain_done (bounded)
    task automatic run_drain(input int cnt, input logic [4:0] sh, input bit inject);
        int cyc;
        cap_data.delete();
        cap_addr.delete();
        cap_last.delete();
        first_valid  = -1;
        done_cyc     = -1;
        drain_count  = cnt[AW:0];
        shift        = sh;
        ob.out_ready = 1'b1;
        drain_start  = 1'b1;
        tick();
        drain_start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 300) begin
            if (ob.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                cap_data.push_back(ob.out_data);
                cap_addr.push_back(ob.out_addr);
                cap_last.push_back(ob.out_last);
            end
            if (drain_done) done_cyc = cyc;
            if (inject && cyc == 2) begin
                acc_enable = 1'b1;
                acc_clear  = 1'b1;
                acc_addr   = 10'd13;
                pe_acc_out = all_lanes(99);
            end else begin
                acc_enable = 1'b0;
                acc_clear  = 1'b0;
            end
            tick();
            cyc++;
        end
        acc_enable = 1'b0;
        acc_clear  = 1'b0;
        check("drain_terminates", done_cyc >= 0, 1'b1);
    endtask

    initial begin
        int cyc;
        bit stalled;
        bit done_seen;
        rst_n = 1'b0;
        acc_enable = 1'b0;
        acc_clear = 1'b0;
        acc_addr = '0;
        pe_acc_out = '0;
        drain_start = 1'b0;
        drain_count = '0;
        shift = 5'd0;
        ob.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", ob.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drain_done", drain_done, 1'b0);
        check("rst_flags", {acc_overflow, err_collision}, 2'b00);
        check("rst_out_data", ob.out_data, '0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 16; a++) strobe(1'b1, a[AW-1:0], all_lanes(0));

        // clear then accumulate with a long gap
        strobe(1'b1, 10'd5, all_lanes(10));
        strobe(1'b0, 10'd5, all_lanes(3));
        for (int k = 0; k < 20; k++) tick();
        strobe(1'b0, 10'd5, all_lanes(3));
        tick();
        tick();
        run_drain(6, 5'd0, 1'b0);
        check("t1_count", cap_data.size(), 6);
        check("t1_latency", first_valid, 5);
        check("t1_done_cyc", done_cyc, 21);
        check("t1_entry5", cap_data[5], exp_all(16));
        check("t1_entry0", cap_data[0], exp_all(0));
        check("t1_addr5", cap_addr[5], 10'd5);
        check("t1_last5", cap_last[5], 1'b1);
        check("t1_last4", cap_last[4], 1'b0);
        check("t1_no_ovf", acc_overflow, 1'b0);

        // back-to-back strobes to the same address, drain immediately after
        strobe(1'b1, 10'd7, all_lanes(100));
        strobe(1'b0, 10'd7, all_lanes(-30));
        run_drain(8, 5'd0, 1'b0);
        check("t2_hazard", cap_data[7], exp_all(70));
        check("t2_entry5", cap_data[5], exp_all(16));
        check("t2_done_cyc", done_cyc, 27);

        // requantization boundaries
        strobe(1'b1, 10'd9, pack32(req_in));
        run_drain(10, 5'd3, 1'b0);
        check("t3_shift3", cap_data[9], exp_lanes(req_s3));
        run_drain(10, 5'd0, 1'b0);
        check("t3_shift0", cap_data[9], exp_lanes(req_s0));
        check("t3_addr9", cap_addr[9], 10'd9);

        // backpressure on entry 1
        strobe(1'b1, 10'd1, all_lanes(55));
        cap_addr.delete();
        cap_data.delete();
        drain_count = 11'd3;
        shift = 5'd0;
        ob.out_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        cyc = 0;
        stalled = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            if (ob.out_valid) begin
                if (ob.out_addr == 10'd1 && !stalled) begin
                    ob.out_ready = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        tick();
                        check("bp_valid", ob.out_valid, 1'b1);
                        check("bp_data", ob.out_data, exp_all(55));
                        check("bp_addr", ob.out_addr, 10'd1);
                    end
                    ob.out_ready = 1'b1;
                    stalled = 1'b1;
                end
                cap_addr.push_back(ob.out_addr);
                cap_data.push_back(ob.out_data);
            end
            tick();
            cyc++;
            if (drain_done) done_seen = 1'b1;
        end
        check("bp_done", done_seen, 1'b1);
        check("bp_count", cap_addr.size(), 3);
        check("bp_seq", {cap_addr[0], cap_addr[1], cap_addr[2]}, {10'd0, 10'd1, 10'd2});
        check("bp_data2", cap_data[2], exp_all(0));

        // overflow and collision flags
        strobe(1'b1, 10'd12, all_lanes(32'h7FFFFFFF));
        strobe(1'b0, 10'd12, all_lanes(1));
        check("ovf_clear_write", acc_overflow, 1'b0);
        tick();
        check("ovf_set", acc_overflow, 1'b1);
        run_drain(14, 5'd0, 1'b1);
        check("coll_set", err_collision, 1'b1);
        check("ovf_cleared", acc_overflow, 1'b0);
        check("ovf_wrap", cap_data[12], exp_all(-128));
        check("coll_dropped", cap_data[13], exp_all(0));
        check("t5_done_cyc", done_cyc, 45);

        // zero-count drain
        run_drain(0, 5'd0, 1'b0);
        check("cnt0_done_cyc", done_cyc, 1);
        check("cnt0_no_valid", cap_data.size(), 0);
        check("coll_cleared", err_collision, 1'b0);

        // asynchronous reset mid-drain
        drain_count = 11'd5;
        shift = 5'd0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        cyc = 1;
        while (!ob.out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rst_pre_valid", ob.out_valid, 1'b1);
        check("rst_pre_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", ob.out_valid, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        tick();
        tick();
        check("rst_no_done", drain_done, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_after_idle", {busy, ob.out_valid, drain_done}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
Downstream partial-sum store for the 16x16 PE array convolution path. It accumulates the bottom-row outputs of the PE array (ARRAY_DIM x 32-bit lanes) into an addressed buffer under the pe_controller's acc_enable/acc_clear/acc_addr strobes. After the controller signals done, it drains the finished output pixels through requantization (round, shift, saturate to int8) onto a valid/ready stream for the output writer.

Parameters:
ARRAY_DIM, 16, number of lanes (PE columns) per entry
ACC_W, 32, accumulator lane width (signed)
DEPTH, 1024, number of entries (MAX_H*MAX_W output pixels)
ADDR_W, 10, entry address width (log2 DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset
acc_enable  in  1  accumulate strobe, one entry per cycle
acc_clear  in  1  qualifies acc_enable: overwrite instead of add
acc_addr  in  ADDR_W  entry address for this strobe
pe_acc_out  in  ARRAY_DIM*ACC_W  lane values; lane i = bits [i*ACC_W +: ACC_W]
drain_start  in  1  single-cycle pulse that starts a drain
drain_count  in  ADDR_W+1  entries to drain, addresses 0..drain_count-1
shift  in  5  requant right-shift amount, 0..31
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  ARRAY_DIM*8  int8 lanes, same lane order as input
out_addr  out  ADDR_W  entry address of out_data
out_last  out  1  high with the final drained entry
busy  out  1  drain in progress
drain_done  out  1  single-cycle pulse after the last entry is accepted
acc_overflow  out  1  sticky: signed lane overflow during an add
err_collision  out  1  sticky: acc_enable asserted while busy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset clears all outputs, the FSM (to S_IDLE), and the pipelines. Buffer RAM contents are not reset; the first kernel slice uses acc_clear.
- Accumulate pipeline (2 stages):
  - Stage 0 registers addr/clear/data and reads RAM.
  - Stage 1 writes mem[addr] = clear ? data : mem[addr] + data, per lane, two's-complement wrap.
  - Sustains one strobe per cycle.
  - Read-after-write hazard: if stage 0 addr equals stage 1 addr, forward stage-1 write data instead of the RAM read.
  - Back-to-back identical addresses must accumulate correctly.
- acc_overflow sets when any lane add has both operands of the same sign and a result of the other sign. Never set on clear writes. Cleared only by reset or drain_start.
- Strobes are accepted only in S_IDLE. If acc_enable is high while busy, the write is dropped and err_collision is set (sticky until reset or drain_start).
- FSM:
  - S_IDLE: on drain_start, latch drain_count and shift and clear flags. If count == 0, pulse drain_done next cycle and stay in S_IDLE. Otherwise go to S_WAIT_PIPE.
  - S_WAIT_PIPE: wait 2 cycles so in-flight accumulate writes retire, then go to S_RD with idx = 0.
  - S_RD: issue RAM read of idx, go to S_LOAD.
  - S_LOAD: requantize the read data, register it into out_data/out_addr, assert out_valid, set out_last = (idx == count-1), go to S_OUT.
  - S_OUT: hold outputs stable while out_ready is low. On out_valid & out_ready, drop out_valid. If last, pulse drain_done and go to S_IDLE. Else idx++ and go to S_RD.
- busy is high in every state except S_IDLE.
- Throughput: one entry per 3 cycles with out_ready held high. Latency from drain_start to first out_valid is 5 cycles.
- drain_start while busy is ignored.
- Requant per lane, done in ACC_W+1 bits:
  - If shift > 0, add 2^(shift-1) then arithmetic shift right by shift (round half up).
  - Saturate to [-128, 127].
  - shift = 0 passes the value through to saturation.
- Reset mid-drain: out_valid drops immediately; no drain_done is issued.

Optional Feature:
PSUM_RELU_EN
- Defined: after saturation, negative lanes are forced to 0, applied per lane independently.
- Undefined: signed int8 output, no ReLU logic.

Test Plan:
- Clear then accumulate: clear addr 5 with all lanes = 10, then add 3 twice (20 cycles apart), drain count 6, shift 0 -> entry 5 lanes = 16; out_last on addr 5; drain_done 1 cycle after accept.
- Hazard: strobes to addr 7 on consecutive cycles (clear 100, then add -30) -> drain reads 70 on all lanes.
- Requant: lanes {1000, -1000, 383, -129, 6, 7}, shift 3 -> {125, -125, 48, -16, 1, 1}. Lanes 100000 and -100000, shift 0 -> 127 and -128. With PSUM_RELU_EN, all negatives read 0.
- Backpressure: drain count 3 with out_ready low for 10 cycles on entry 1 -> out_data/out_addr stable, no entry skipped, out_addr sequence 0, 1, 2.
- Flags: add 0x7FFFFFFF + 1 -> acc_overflow = 1. acc_enable during busy -> err_collision = 1 and the targeted entry is unchanged. Next drain_start clears both flags.
- Edge/reset: drain_count 0 -> drain_done pulse with no out_valid. rst_n low mid-drain -> out_valid and busy go to 0 asynchronously.
